// File: rtl/board_draw_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : board_draw_sequencer
// Purpose  : Redraws the 4x4 sliding-puzzle board. On start, each of the 16
//            tiles is filled with a solid square, then for non-blank tiles the
//            external digit drawer is reset, enabled, and its pixel stream is
//            forwarded to the VGA plot outputs.
// Ports    : clk, resetn (sync, active low)
//            start, board[63:0]       - redraw request / tile values (4b each)
//            busy, done               - redraw in progress / completion pulse
//            digit, base_x, base_y    - drawer select and tile origin
//            drawer_en, drawer_resetn - digit drawer control
//            digit_x, digit_y         - pixel coordinates from the drawer
//            plot_x, plot_y, colour, plot - VGA adapter write port
// Option   : HIGHLIGHT_EN - adds input hl_pos[3:0] and parameter HL_COLOUR;
//            the non-blank tile at hl_pos is filled with HL_COLOUR.
// Revision : 1.0 - initial release
// ============================================================================
module board_draw_sequencer #(
  parameter int          TILE_SIZE    = 30,
  parameter int          ORIGIN_X     = 20,
  parameter int          ORIGIN_Y     = 0,
  parameter int          DIGIT_CYCLES = 101,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter logic [2:0]  TILE_COLOUR  = 3'b001,
`ifdef HIGHLIGHT_EN
  parameter logic [2:0]  HL_COLOUR    = 3'b100,
`endif
  parameter logic [2:0]  FG_COLOUR    = 3'b111
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [63:0] board,
`ifdef HIGHLIGHT_EN
  input  logic [3:0]  hl_pos,
`endif
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit,
  output logic [7:0]  base_x,
  output logic [6:0]  base_y,
  output logic        drawer_en,
  output logic        drawer_resetn,
  input  logic [7:0]  digit_x,
  input  logic [6:0]  digit_y,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  colour,
  output logic        plot
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_DRST  = 3'd2;
  localparam logic [2:0] S_DIGIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int DCW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  localparam logic [7:0]     C_LAST_X = 8'(TILE_SIZE - 1);
  localparam logic [6:0]     C_LAST_Y = 7'(TILE_SIZE - 1);
  localparam logic [DCW-1:0] C_DLAST  = DCW'(DIGIT_CYCLES - 1);

  logic [2:0]     r_state, w_nextState;
  logic [3:0]     r_pos, w_nextPos;
  logic [7:0]     r_cx, w_nextCx;
  logic [6:0]     r_cy, w_nextCy;
  logic [DCW-1:0] r_dcnt, w_nextDcnt;
  logic [63:0]    r_board;
  logic           w_load;
  logic           w_advance;
  logic           w_drawerRstn;
  logic [2:0]     w_fillColour;
`ifdef HIGHLIGHT_EN
  logic [3:0]     r_hlPos;
`endif

  // Tile geometry; arithmetic is done at port width so results wrap naturally.
  assign digit  = r_board[{r_pos, 2'b00} +: 4];
  assign base_x = 8'(ORIGIN_X) + 8'(TILE_SIZE) * {6'd0, r_pos[1:0]};
  assign base_y = 7'(ORIGIN_Y) + 7'(TILE_SIZE) * {5'd0, r_pos[3:2]};

  always_comb begin
    w_fillColour = TILE_COLOUR;
    if (digit == 4'd0) begin
      w_fillColour = BG_COLOUR;
    end
`ifdef HIGHLIGHT_EN
    else if (r_pos == r_hlPos) begin
      w_fillColour = HL_COLOUR;
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_pos   <= 4'd0;
      r_cx    <= 8'd0;
      r_cy    <= 7'd0;
      r_dcnt  <= '0;
      r_board <= 64'd0;
`ifdef HIGHLIGHT_EN
      r_hlPos <= 4'd0;
`endif
    end else begin
      r_state <= w_nextState;
      r_pos   <= w_nextPos;
      r_cx    <= w_nextCx;
      r_cy    <= w_nextCy;
      r_dcnt  <= w_nextDcnt;
      if (w_load) begin
        r_board <= board;
`ifdef HIGHLIGHT_EN
        r_hlPos <= hl_pos;
`endif
      end
    end
  end

  // Next-state logic. cx/cy are already back at zero when a tile finishes,
  // so moving to the next position only has to bump p.
  always_comb begin
    w_nextState = r_state;
    w_nextPos   = r_pos;
    w_nextCx    = r_cx;
    w_nextCy    = r_cy;
    w_nextDcnt  = r_dcnt;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nextState = S_CLEAR;
          w_nextPos   = 4'd0;
          w_nextCx    = 8'd0;
          w_nextCy    = 7'd0;
          w_load      = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_cx == C_LAST_X) begin
          w_nextCx = 8'd0;
          if (r_cy == C_LAST_Y) begin
            w_nextCy = 7'd0;
            if (digit != 4'd0) begin
              w_nextState = S_DRST;
            end else begin
              w_advance = 1'b1;
            end
          end else begin
            w_nextCy = r_cy + 7'd1;
          end
        end else begin
          w_nextCx = r_cx + 8'd1;
        end
      end
      S_DRST: begin
        w_nextState = S_DIGIT;
        w_nextDcnt  = '0;
      end
      S_DIGIT: begin
        if (r_dcnt == C_DLAST) begin
          w_advance = 1'b1;
        end else begin
          w_nextDcnt = r_dcnt + 1'b1;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
    if (w_advance) begin
      if (r_pos == 4'd15) begin
        w_nextState = S_DONE;
      end else begin
        w_nextState = S_CLEAR;
        w_nextPos   = r_pos + 4'd1;
      end
    end
  end

  // Output decode
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    plot         = 1'b0;
    drawer_en    = 1'b0;
    w_drawerRstn = 1'b1;
    plot_x       = 8'd0;
    plot_y       = 7'd0;
    colour       = 3'd0;
    case (r_state)
      S_CLEAR: begin
        busy   = 1'b1;
        plot   = 1'b1;
        plot_x = base_x + r_cx;
        plot_y = base_y + r_cy;
        colour = w_fillColour;
      end
      S_DRST: begin
        busy         = 1'b1;
        w_drawerRstn = 1'b0;
      end
      S_DIGIT: begin
        busy      = 1'b1;
        drawer_en = 1'b1;
        plot      = 1'b1;
        plot_x    = digit_x;
        plot_y    = digit_y;
        colour    = FG_COLOUR;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The drawer is also held in reset while our own reset is asserted.
  assign drawer_resetn = resetn & w_drawerRstn;

endmodule
`default_nettype wire

// File: tb/tb_board_draw_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_board_draw_sequencer
// Purpose  : Scoreboard bench for board_draw_sequencer. The stimulus side
//            pushes every expected plot pixel into a queue; a monitor pops
//            and compares whenever plot is high. A small drawer model answers
//            digit_x/digit_y from a counter reset by drawer_resetn.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_draw_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [63:0] board = 64'd0;
`ifdef HIGHLIGHT_EN
  logic [3:0]  hl_pos = 4'd0;
`endif
  logic        busy, done, drawer_en, drawer_resetn, plot;
  logic [3:0]  digit;
  logic [7:0]  base_x, digit_x, plot_x;
  logic [6:0]  base_y, digit_y, plot_y;
  logic [2:0]  colour;

  localparam logic [63:0] SOLVED = 64'h0FED_CBA9_8765_4321;

  board_draw_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .board(board),
`ifdef HIGHLIGHT_EN
    .hl_pos(hl_pos),
`endif
    .busy(busy), .done(done), .digit(digit), .base_x(base_x), .base_y(base_y),
    .drawer_en(drawer_en), .drawer_resetn(drawer_resetn),
    .digit_x(digit_x), .digit_y(digit_y),
    .plot_x(plot_x), .plot_y(plot_y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  // Drawer model: pixel k of a 10-wide raster relative to the tile origin.
  int k = 0;
  always @(posedge clk) begin
    if (!drawer_resetn) k <= 0;
    else if (drawer_en) k <= k + 1;
  end
  assign digit_x = base_x + 8'(k % 10);
  assign digit_y = base_y + 7'(k / 10);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       en;
    logic [3:0] dig;
  } pix_t;

  pix_t q[$];
  pix_t mExp, mAct;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every plotted pixel against the scoreboard.
  always @(negedge clk) begin
    if (resetn) begin
      if (plot) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL plot-overrun: pixel (%0d,%0d) plotted with none expected", plot_x, plot_y);
        end else begin
          mExp = q.pop_front();
          mAct = {plot_x, plot_y, colour, drawer_en, digit};
          checks++;
          if (mAct !== mExp) begin
            errors++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0d en=%0d dig=%0d, expected x=%0d y=%0d c=%0d en=%0d dig=%0d",
                     mAct.x, mAct.y, mAct.c, mAct.en, mAct.dig,
                     mExp.x, mExp.y, mExp.c, mExp.en, mExp.dig);
          end
        end
      end else begin
        chk("drawer_en-while-not-plotting", drawer_en, 0);
        if (busy) chk("drawer_resetn-in-DRST", drawer_resetn, 0);
      end
    end
  end

  // Expected plot stream for a whole redraw.
  task automatic pushModel(input logic [63:0] b, input int hl);
    pix_t r;
    logic [3:0] t;
    int bx, by;
    for (int p = 0; p < 16; p++) begin
      t  = b[4*p +: 4];
      bx = 20 + (p % 4) * 30;
      by = (p / 4) * 30;
      for (int cy = 0; cy < 30; cy++) begin
        for (int cx = 0; cx < 30; cx++) begin
          r.x   = 8'(bx + cx);
          r.y   = 7'(by + cy);
          r.c   = (t == 4'd0) ? 3'd0 : ((p == hl) ? 3'd4 : 3'd1);
          r.en  = 1'b0;
          r.dig = t;
          q.push_back(r);
        end
      end
      if (t != 4'd0) begin
        for (int j = 0; j < 101; j++) begin
          r.x   = 8'(bx + j % 10);
          r.y   = 7'(by + j / 10);
          r.c   = 3'd7;
          r.en  = 1'b1;
          r.dig = t;
          q.push_back(r);
        end
      end
    end
  endtask

  // n counts clock edges after the one that samples start.
  task automatic runDraw(input logic [63:0] b, input int hl, input bit disturb, input int abortAt);
    int nz, expDone, lastClearN, n, busyCnt, hlModel;
    bit gotDone;
    nz = 0;
    for (int p = 0; p < 16; p++) if (b[4*p +: 4] != 4'd0) nz++;
    expDone    = 16 * 900 + nz * 102 + 1;
    lastClearN = expDone - 1 - ((b[63:60] != 4'd0) ? 102 : 0);
`ifdef HIGHLIGHT_EN
    hlModel = (hl < 0) ? 15 : hl;
`else
    hlModel = -1;
`endif
    q.delete();
    pushModel(b, hlModel);
    @(negedge clk);
    board = b;
`ifdef HIGHLIGHT_EN
    hl_pos = 4'(hlModel);
`endif
    start   = 1'b1;
    busyCnt = 0;
    gotDone = 1'b0;
    n       = 0;
    while (!gotDone && n < expDone + 20) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (disturb && (n == 300 || n == 9000)) begin
        start = 1'b1;
        board = ~b;
      end
      if (n == 1) begin
        chk("busy-after-start", busy, 1);
        chk("first-pixel-x", plot_x, 20);
        chk("first-pixel-y", plot_y, 0);
        chk("first-pixel-colour", colour, (b[3:0] == 4'd0) ? 0 : 1);
      end
      if (n == 901 && b[3:0] != 4'd0) begin
        chk("tile0-DRST-drawer_resetn", drawer_resetn, 0);
        chk("tile0-DRST-plot", plot, 0);
      end
      if (b[3:0] != 4'd0 && (n == 902 || n == 1002)) chk("tile0-DIGIT-drawer_en", drawer_en, 1);
      if (b[3:0] != 4'd0 && n == 1003) chk("tile1-CLEAR-drawer_en", drawer_en, 0);
      if (abortAt != 0 && n == abortAt) begin
        resetn = 1'b0;
        @(negedge clk);
        chk("abort-plot", plot, 0);
        chk("abort-busy", busy, 0);
        chk("abort-done", done, 0);
        chk("abort-drawer_resetn", drawer_resetn, 0);
        resetn = 1'b1;
        q.delete();
        repeat (5) begin
          @(negedge clk);
          chk("no-done-after-abort", done, 0);
          chk("idle-after-abort", busy, 0);
        end
        return;
      end
      if (n == lastClearN) begin
        chk("last-pixel-x", plot_x, 139);
        chk("last-pixel-y", plot_y, 119);
        chk("last-base-x", base_x, 110);
        chk("last-base-y", base_y, 90);
      end
      if (busy) busyCnt++;
      if (done) begin
        gotDone = 1'b1;
        chk("done-cycle", n, expDone);
        chk("busy-at-done", busy, 0);
      end
    end
    if (!gotDone) begin
      checks++;
      errors++;
      $display("FAIL done-timeout: no done within %0d cycles, expected at %0d", n, expDone);
    end
    chk("busy-cycles", busyCnt, expDone - 1);
    @(negedge clk);
    chk("done-single-pulse", done, 0);
    chk("scoreboard-drained", q.size(), 0);
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset-drawer_resetn", drawer_resetn, 0);
    chk("reset-plot", plot, 0);
    chk("reset-busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle-busy", busy, 0);
    chk("idle-done", done, 0);
    chk("idle-drawer_en", drawer_en, 0);
    chk("idle-drawer_resetn", drawer_resetn, 1);
    chk("idle-plot_x", plot_x, 0);
    chk("idle-plot_y", plot_y, 0);
    chk("idle-colour", colour, 0);
    chk("idle-digit", digit, 0);

    runDraw(64'd0, -1, 1'b0, 0);        // blank board
    runDraw(SOLVED, -1, 1'b0, 0);       // solved board
    runDraw(SOLVED, -1, 1'b1, 0);       // start/board changes mid-redraw
    runDraw(SOLVED, -1, 1'b0, 500);     // reset mid-redraw
    runDraw(64'h3, -1, 1'b0, 0);        // fresh redraw after abort
`ifdef HIGHLIGHT_EN
    runDraw(SOLVED, 5, 1'b0, 0);        // highlighted tile 6
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
